// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the frame reader.
// Defaults describe an 800x480 panel.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int HDISP_DEF = 800;
    localparam int VDISP_DEF = 480;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_reader_if.sv
// Pixel stream handshake: word plus start-of-frame tag.
// master is the source side, slave the sink side.
interface frame_reader_if;
    logic [31:0] data;
    logic        sof;
    logic        valid;
    logic        ready;

    modport master (
        output data,
        output sof,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  sof,
        input  valid,
        output ready
    );
endinterface

// File: rtl/frame_reader_fifo.sv
// Synchronous first-word-fall-through FIFO carrying a word and sof tag.
// The head is gated to zero while empty so the stream idles clean.
module frame_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [31:0]   data_i,
    input  logic          sof_i,
    output logic [CW-1:0] count_o,
    frame_reader_if.master px
);

    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic [32:0]   head;
    logic          pop;

    assign pop  = px.valid & px.ready;
    assign head = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= {sof_i, data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop)    rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop);
        end
    end

    assign count_o  = cnt_q;
    assign px.valid = (cnt_q != '0);
    assign px.data  = px.valid ? head[31:0] : 32'h0;
    assign px.sof   = px.valid & head[32];

endmodule

// File: rtl/frame_reader.sv
// Wishbone frame fetcher: reads a frame word by word into a FWFT FIFO,
// one request in flight, stopping only at frame boundaries.
module frame_reader
    import video_pkg::*;
#(
    parameter int          HDISP      = HDISP_DEF,
    parameter int          VDISP      = VDISP_DEF,
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_sm,
    input  logic        wb_ack,
    output logic [31:0] px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        px_sof,
    output logic        frame_done
);

    localparam int N  = HDISP * VDISP;
    localparam int KW = cnt_w(N);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
    localparam logic [CW:0]   DEPTH_X = (CW + 1)'(FIFO_DEPTH);

    state_e        state_q;
    logic          cyc_q;
    logic          done_q;
    logic [31:0]   adr_q;
    logic [KW-1:0] k_q;

    logic [CW-1:0] count;
    logic [CW:0]   fill_d;
    logic          push;
    logic          pop;
    logic          last;
    logic          room_now;
    logic          room_next;

    frame_reader_if px_bus ();

    assign push = (state_q == REQ) & wb_ack;
    assign pop  = px_bus.valid & px_ready;
    assign last = (k_q == K_LAST);

    // Fill level after this cycle's push/pop decides whether to keep requesting.
    assign fill_d    = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);
    assign room_next = (fill_d < DEPTH_X);
    assign room_now  = ({1'b0, count} < DEPTH_X);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            adr_q   <= BASE_ADR;
            k_q     <= '0;
        end else begin
            done_q <= push & last;
            unique case (state_q)
                IDLE: begin
                    if (enable && room_now) begin
                        state_q <= REQ;
                        cyc_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (wb_ack) begin
                        k_q   <= last ? '0 : k_q + 1'b1;
                        adr_q <= last ? BASE_ADR : adr_q + 32'd4;
                        if (last && !enable) begin
                            state_q <= IDLE;
                            cyc_q   <= 1'b0;
                        end else if (room_next) begin
                            state_q <= REQ;
                            cyc_q   <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cyc_q   <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (room_now) begin
                        state_q <= REQ;
                        cyc_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (push),
        .data_i  (wb_dat_sm),
        .sof_i   (k_q == '0),
        .count_o (count),
        .px      (px_bus)
    );

    assign px_bus.ready = px_ready;

    assign wb_cyc     = cyc_q;
    assign wb_stb     = cyc_q;
    assign wb_we      = 1'b0;
    assign wb_sel     = 4'hF;
    assign wb_adr     = adr_q;
    assign frame_done = done_q;
    assign px_data    = px_bus.data;
    assign px_valid   = px_bus.valid;
    assign px_sof     = px_bus.sof;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: random-data Wishbone slave plus a queue model
// of the pixel stream, driven through one task per scenario.
module tb_frame_reader;

    localparam int          HD    = 4;
    localparam int          VD    = 2;
    localparam int          NW    = HD * VD;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [31:0] d;
        logic        s;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wb_cyc, wb_stb, wb_we, frame_done;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_sm = 32'h0;
    logic        wb_ack = 1'b0;
    logic [31:0] px_data;
    logic        px_valid, px_sof;
    logic        px_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int acks = 0;
    int done_exp = 0;
    int done_seen = 0;
    int pops = 0;
    int sofs = 0;
    ent_t q[$];

    int          ack_delay = 0;
    bit          stray = 1'b0;
    int          wcnt = 0;
    logic [31:0] hold_adr = 32'h0;
    bit          rnd_ready = 1'b0;
    bit          ready_force = 1'b0;

    always #5 clk = ~clk;

    frame_reader_if bus ();
    assign bus.data  = px_data;
    assign bus.sof   = px_sof;
    assign bus.valid = px_valid;
    assign bus.ready = px_ready;

    frame_reader #(
        .HDISP      (HD),
        .VDISP      (VD),
        .BASE_ADR   (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .enable     (enable),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_adr     (wb_adr),
        .wb_sel     (wb_sel),
        .wb_dat_sm  (wb_dat_sm),
        .wb_ack     (wb_ack),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_sof     (px_sof),
        .frame_done (frame_done)
    );

    // Slave: acks after ack_delay stalled cycles, predicts address k*4.
    always @(negedge clk) begin
        logic [31:0] exp_adr;
        logic [31:0] dat;
        if (!rst_n) begin
            wb_ack = 1'b0;
            wcnt = 0;
        end else if (wb_ack) begin
            wb_ack = 1'b0;
            wcnt = 0;
        end else if (wb_stb) begin
            if (wcnt == 0) begin
                hold_adr = wb_adr;
            end else begin
                vectors++;
                if (wb_adr !== hold_adr) begin
                    miscompares++;
                    $display("FAIL adr_hold: got %h want %h", wb_adr, hold_adr);
                end
            end
            if (wcnt >= ack_delay) begin
                exp_adr = BASE + 32'(4 * (acks % NW));
                vectors++;
                if (wb_adr !== exp_adr || wb_cyc !== 1'b1) begin
                    miscompares++;
                    $display("FAIL req_adr: got %h cyc %b want %h cyc 1",
                             wb_adr, wb_cyc, exp_adr);
                end
                dat = $urandom;
                wb_dat_sm = dat;
                wb_ack = 1'b1;
                q.push_back('{dat, ((acks % NW) == 0)});
                if ((acks % NW) == NW - 1) done_exp++;
                acks++;
            end else begin
                wcnt++;
            end
        end else if (stray) begin
            wb_ack = 1'b1;
            wb_dat_sm = $urandom;
        end
    end

    // Stream monitor: pops against the model queue, checks stall hold.
    bit          prev_stall = 1'b0;
    bit          prev_done = 1'b0;
    logic [31:0] prev_d = 32'h0;
    logic        prev_s = 1'b0;

    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (frame_done) begin
                done_seen++;
                vectors++;
                if (prev_done) begin
                    miscompares++;
                    $display("FAIL done_width: got 2+ cycles want 1");
                end
            end
            prev_done = frame_done;
            if (px_valid && prev_stall) begin
                vectors++;
                if (px_data !== prev_d || px_sof !== prev_s) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h/%b want %h/%b",
                             px_data, px_sof, prev_d, prev_s);
                end
            end
            if (px_valid && px_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL px_extra: got %h want none", px_data);
                end else begin
                    e = q.pop_front();
                    if (px_data !== e.d || px_sof !== e.s) begin
                        miscompares++;
                        $display("FAIL px_word: got %h/%b want %h/%b",
                                 px_data, px_sof, e.d, e.s);
                    end
                end
                pops++;
                if (px_sof) sofs++;
            end
            prev_stall = px_valid && !px_ready;
            prev_d = px_data;
            prev_s = px_sof;
        end
    end

    always @(posedge clk) begin
        #1;
        px_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_acks(input int target, input int limit);
        int n = 0;
        while (acks < target && n < limit) begin
            tick(1);
            n++;
        end
        if (acks < target) begin
            miscompares++;
            $display("FAIL ack_timeout: got %0d want %0d", acks, target);
        end
    endtask

    task automatic drain();
        rnd_ready = 1'b0;
        ready_force = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        tick(3);
        vectors += 4;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_cyc: got %b%b want 00", wb_cyc, wb_stb);
        end
        if (wb_adr !== BASE) begin
            miscompares++;
            $display("FAIL rst_adr: got %h want %h", wb_adr, BASE);
        end
        if (px_valid !== 1'b0 || px_sof !== 1'b0 || px_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_px: got %b%b %h want 00 0", px_valid, px_sof, px_data);
        end
        if (frame_done !== 1'b0 || wb_we !== 1'b0 || wb_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL rst_misc: got %b %b %h want 0 0 f", frame_done, wb_we, wb_sel);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_frame();
        int a0 = acks;
        int ds0 = done_seen;
        int s0 = sofs;
        ack_delay = 0;
        rnd_ready = 1'b0;
        ready_force = 1'b1;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        wait_acks(a0 + NW, 200);
        tick(10);
        vectors += 4;
        if (acks - a0 !== NW) begin
            miscompares++;
            $display("FAIL single_acks: got %0d want %0d", acks - a0, NW);
        end
        if (done_seen - ds0 !== 1 || done_seen !== done_exp) begin
            miscompares++;
            $display("FAIL single_done: got %0d want 1", done_seen - ds0);
        end
        if (sofs - s0 !== 1) begin
            miscompares++;
            $display("FAIL single_sof: got %0d want 1", sofs - s0);
        end
        if (wb_stb !== 1'b0 || px_valid !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL single_idle: got stb %b valid %b q %0d want 0 0 0",
                     wb_stb, px_valid, q.size());
        end
    endtask

    task automatic test_backpressure();
        int a0 = acks;
        ack_delay = 0;
        rnd_ready = 1'b0;
        ready_force = 1'b0;
        enable = 1'b1;
        tick(40);
        vectors += 2;
        if (acks - a0 !== DEPTH) begin
            miscompares++;
            $display("FAIL bp_fill: got %0d want %0d", acks - a0, DEPTH);
        end
        if (wb_stb !== 1'b0 || px_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stall: got stb %b valid %b want 0 1", wb_stb, px_valid);
        end
        ready_force = 1'b1;
        tick(1);
        ready_force = 1'b0;
        tick(20);
        vectors += 2;
        if (acks - a0 !== DEPTH + 1) begin
            miscompares++;
            $display("FAIL bp_one: got %0d want %0d", acks - a0, DEPTH + 1);
        end
        if (wb_stb !== 1'b0 || q.size() != DEPTH) begin
            miscompares++;
            $display("FAIL bp_refill: got stb %b q %0d want 0 %0d", wb_stb, q.size(), DEPTH);
        end
        enable = 1'b0;
        ready_force = 1'b1;
        wait_acks(a0 + NW, 300);
        tick(10);
        vectors++;
        if (done_seen !== done_exp || q.size() != 0 || wb_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_end: got done %0d q %0d stb %b want %0d 0 0",
                     done_seen, q.size(), wb_stb, done_exp);
        end
    endtask

    task automatic test_slow_ack();
        int a0 = acks;
        int p0 = pops;
        ack_delay = 5;
        rnd_ready = 1'b1;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        wait_acks(a0 + NW, 600);
        tick(10);
        drain();
        vectors += 2;
        if (acks - a0 !== NW || pops - p0 !== NW) begin
            miscompares++;
            $display("FAIL slow_count: got acks %0d pops %0d want %0d",
                     acks - a0, pops - p0, NW);
        end
        if (done_seen !== done_exp || wb_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL slow_end: got done %0d stb %b want %0d 0",
                     done_seen, wb_stb, done_exp);
        end
        ack_delay = 0;
    endtask

    task automatic test_enable_drop();
        int a0 = acks;
        ack_delay = 0;
        rnd_ready = 1'b1;
        enable = 1'b1;
        wait_acks(a0 + 4, 200);
        enable = 1'b0;
        wait_acks(a0 + NW, 300);
        tick(10);
        drain();
        tick(10);
        vectors += 2;
        if (acks - a0 !== NW) begin
            miscompares++;
            $display("FAIL drop_acks: got %0d want %0d", acks - a0, NW);
        end
        if (done_seen !== done_exp || wb_stb !== 1'b0 || wb_cyc !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_idle: got done %0d cyc %b want %0d 0",
                     done_seen, wb_cyc, done_exp);
        end
    endtask

    task automatic test_two_frames();
        int a0 = acks;
        int ds0 = done_seen;
        int s0 = sofs;
        ack_delay = $urandom_range(0, 2);
        rnd_ready = 1'b1;
        enable = 1'b1;
        wait_acks(a0 + NW + 2, 400);
        enable = 1'b0;
        wait_acks(a0 + 2 * NW, 400);
        tick(10);
        drain();
        vectors += 2;
        if (acks - a0 !== 2 * NW || done_seen - ds0 !== 2) begin
            miscompares++;
            $display("FAIL two_count: got acks %0d done %0d want %0d 2",
                     acks - a0, done_seen - ds0, 2 * NW);
        end
        if (sofs - s0 !== 2 || q.size() != 0) begin
            miscompares++;
            $display("FAIL two_sof: got %0d q %0d want 2 0", sofs - s0, q.size());
        end
        ack_delay = 0;
    endtask

    task automatic test_stray_ack();
        int a0 = acks;
        enable = 1'b0;
        stray = 1'b1;
        tick(10);
        stray = 1'b0;
        tick(3);
        vectors++;
        if (px_valid !== 1'b0 || wb_stb !== 1'b0 || acks !== a0) begin
            miscompares++;
            $display("FAIL stray: got valid %b stb %b want 0 0", px_valid, wb_stb);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ack_delay = 0;
        rnd_ready = 1'b0;
        ready_force = 1'b0;
        enable = 1'b1;
        while (q.size() < 3 && n < 100) begin
            tick(1);
            n++;
        end
        ack_delay = 20;
        tick(2);
        vectors++;
        if (wb_stb !== 1'b1 || px_valid !== 1'b1 || q.size() != 3) begin
            miscompares++;
            $display("FAIL mid_setup: got stb %b valid %b q %0d want 1 1 3",
                     wb_stb, px_valid, q.size());
        end
        rst_n = 1'b0;
        tick(1);
        vectors += 3;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_cyc: got %b%b want 00", wb_cyc, wb_stb);
        end
        if (px_valid !== 1'b0 || px_data !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_flush: got %b %h want 0 0", px_valid, px_data);
        end
        if (wb_adr !== BASE) begin
            miscompares++;
            $display("FAIL mid_adr: got %h want %h", wb_adr, BASE);
        end
        q.delete();
        acks = 0;
        enable = 1'b0;
        ack_delay = 0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_slow_ack();
        test_enable_drop();
        test_two_frames();
        test_stray_ack();
        test_reset_mid();
        test_single_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter HDISP, default 800, pixels per line.
REQ-002 Parameter VDISP, default 480, lines per frame.
REQ-003 Parameter BASE_ADR, default 32'h0000_0000, byte address of frame word 0.
REQ-004 Parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, >=4).
REQ-005 sys_clk  in  1  single clock for the block; all logic on its rising edge.
REQ-006 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-007 enable  in  1  high: fetch frames continuously; low: stop at the next frame boundary.
REQ-008 wb_cyc  out  1  Wishbone cycle.
REQ-009 wb_stb  out  1  Wishbone strobe.
REQ-010 wb_we  out  1  constant 0 (read only).
REQ-011 wb_adr  out  32  byte address, word aligned.
REQ-012 wb_sel  out  4  constant 4'hF.
REQ-013 wb_dat_sm  in  32  read data from slave.
REQ-014 wb_ack  in  1  slave acknowledge.
REQ-015 px_data  out  32  pixel word, FIFO head.
REQ-016 px_valid  out  1  px_data is valid.
REQ-017 px_ready  in  1  sink accepts word when px_valid && px_ready.
REQ-018 px_sof  out  1  high with px_valid on word 0 of each frame.
REQ-019 frame_done  out  1  one-cycle pulse when the last word of a frame is acked.

Function
REQ-020 Word count per frame N = HDISP*VDISP; word k is read at BASE_ADR + 4*k.
REQ-021 States IDLE, REQ, WAIT; IDLE->REQ when enable=1 and FIFO count < FIFO_DEPTH.
REQ-022 In REQ, wb_cyc=wb_stb=1 and wb_adr stay constant until the cycle wb_ack=1.
REQ-023 On ack: wb_dat_sm is pushed into the FIFO with a sof tag (k==0), and k increments the same cycle.
REQ-024 After ack: next state is REQ if FIFO has space for another word, else WAIT; WAIT->REQ once count < FIFO_DEPTH.
REQ-025 Space check counts the word being pushed, so no push is ever lost.
REQ-026 At most one request is outstanding; wb_cyc drops between requests only in WAIT/IDLE.
REQ-027 On ack of word k=N-1: frame_done=1 for one cycle, k wraps to 0, address wraps to BASE_ADR.
REQ-028 At wrap, if enable=0 then go to IDLE, else continue in REQ/WAIT with word 0 of the next frame.
REQ-029 enable deasserted mid-frame does not abort the frame; the frame completes, then IDLE.
REQ-030 FIFO push and pop in the same cycle are both performed; count unchanged.
REQ-031 Pop occurs when px_valid && px_ready; px_valid=1 whenever FIFO is not empty.
REQ-032 px_data/px_sof present the FIFO head with zero added latency (first-word fall-through).
REQ-033 Latency ack -> px_valid on an empty FIFO: 1 cycle.
REQ-034 px_data/px_sof hold stable while px_valid=1 and px_ready=0.
REQ-035 wb_ack outside REQ is ignored.

Reset
REQ-036 With sys_rst_n=0 at a clock edge, state=IDLE, k=0, FIFO empty.
REQ-037 Reset values: wb_cyc=0, wb_stb=0, wb_adr=BASE_ADR, px_valid=0, px_sof=0, frame_done=0, px_data=0.
REQ-038 Reset mid-transfer abandons the request (cyc/stb low next cycle) and flushes the FIFO.

Structure
REQ-039 Package video_pkg holds the state enum, HDISP/VDISP defaults and the word-count width function.
REQ-040 FIFO is sub-module frame_fifo (sync FWFT, data+sof tag, count output).

Verification
REQ-041 HDISP=4, VDISP=2, ack 1 cycle after each stb, px_ready=1 -> words 0..7 read from adr 0x00..0x1C in order, px_sof only on word 0, frame_done pulses once.
REQ-042 px_ready=0, FIFO_DEPTH=4 -> exactly 4 acks, then wb_stb=0; px_ready=1 for one cycle -> exactly one new request.
REQ-043 Slave delays ack by 5 cycles -> wb_adr/stb held constant for all 5 cycles, one push per ack.
REQ-044 enable dropped at word 3 of 8 -> words 4..7 still fetched, frame_done pulses, state IDLE, no further stb.
REQ-045 enable held high over 2 frames -> word 8 address 0x00 with px_sof=1, frame_done twice.
REQ-046 sys_rst_n=0 while wb_stb=1 and FIFO holds 3 words -> next cycle wb_cyc=0, px_valid=0, wb_adr=BASE_ADR.
